// File: rtl/alion_rvfi_chk_pkg.sv
// Shared types and constants for the alion RVFI retire checker.
package alion_rvfi_chk_pkg;

  localparam int unsigned NREGS   = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned ERR_W   = 4;
  localparam int unsigned ORDER_W = 64;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    RUN        = 2'd1,
    HALTED     = 2'd2,
    FAIL       = 2'd3
  } chk_state_e;

  typedef enum logic [ERR_W-1:0] {
    NONE              = 4'd0,
    X0_READ           = 4'd1,
    X0_WRITE          = 4'd2,
    RS_MISMATCH       = 4'd3,
    PC_DISCONT        = 4'd4,
    TRAP_WRITE        = 4'd5,
    ORDER             = 4'd6,
    RETIRE_AFTER_HALT = 4'd7
  } err_code_e;

  // One flag per per-retire check, listed in priority order.
  typedef struct packed {
    logic x0_read;
    logic x0_write;
    logic rs_mismatch;
    logic pc_discont;
    logic trap_write;
    logic order;
  } chk_hits_t;

  // Lowest-numbered failing check wins.
  function automatic err_code_e first_err(input chk_hits_t h);
    if (h.x0_read)     return X0_READ;
    if (h.x0_write)    return X0_WRITE;
    if (h.rs_mismatch) return RS_MISMATCH;
    if (h.pc_discont)  return PC_DISCONT;
    if (h.trap_write)  return TRAP_WRITE;
    if (h.order)       return ORDER;
    return NONE;
  endfunction

endpackage

// File: rtl/alion_shadow_rf.sv
// Shadow register file: 32 x XLEN with per-entry valid bits, x0 never valid.
// Two combinational read ports, one write port; valid bits clear on reset.
module alion_shadow_rf
  import alion_rvfi_chk_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ra_addr,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [XLEN-1:0]   ra_data_c,
  output logic [XLEN-1:0]   rb_data_c,
  output logic              ra_valid_c,
  output logic              rb_valid_c,
  input  logic              we,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_data
);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [XLEN-1:0]  mem_d [NREGS];
  logic [NREGS-1:0] valid_q;
  logic [NREGS-1:0] valid_d;

  // Write path; x0 is never written so it stays invalid.
  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    if (we && (wr_addr != '0)) begin
      mem_d[wr_addr]   = wr_data;
      valid_d[wr_addr] = 1'b1;
    end
  end

  // Data storage needs no reset: it is only trusted behind a valid bit.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Valid bits clear asynchronously so reset discards all history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  assign ra_valid_c = valid_q[ra_addr];
  assign rb_valid_c = valid_q[rb_addr];
  assign ra_data_c  = (ra_addr == '0) ? '0 : mem_q[ra_addr];
  assign rb_data_c  = (rb_addr == '0) ? '0 : mem_q[rb_addr];

endmodule

// File: rtl/alion_rvfi_retire_checker.sv
// Cycle-by-cycle checker for the single-retire RVFI stream of the alion core.
// Optional: define ALION_RVFI_ORDER_CHECK_EN to also check rvfi_order continuity.
module alion_rvfi_retire_checker
  import alion_rvfi_chk_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rvfi_valid,
  input  logic [ORDER_W-1:0] rvfi_order,
  input  logic [31:0]        rvfi_insn,
  input  logic               rvfi_trap,
  input  logic               rvfi_halt,
  input  logic               rvfi_intr,
  input  logic [REG_AW-1:0]  rvfi_rs1_addr,
  input  logic [REG_AW-1:0]  rvfi_rs2_addr,
  input  logic [XLEN-1:0]    rvfi_rs1_rdata,
  input  logic [XLEN-1:0]    rvfi_rs2_rdata,
  input  logic [REG_AW-1:0]  rvfi_rd_addr,
  input  logic [XLEN-1:0]    rvfi_rd_wdata,
  input  logic [XLEN-1:0]    rvfi_pc_rdata,
  input  logic [XLEN-1:0]    rvfi_pc_wdata,
  output logic               err,
  output logic [ERR_W-1:0]   err_code,
  output logic [ORDER_W-1:0] err_order,
  output logic [CNT_W-1:0]   retire_cnt
);

  chk_state_e         state_q, state_d;
  logic               err_q, err_d;
  err_code_e          err_code_q, err_code_d;
  logic [ORDER_W-1:0] err_order_q, err_order_d;
  logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;
  logic [XLEN-1:0]    prev_pc_q, prev_pc_d;

  logic [XLEN-1:0]    sh_rs1_data_c, sh_rs2_data_c;
  logic               sh_rs1_valid_c, sh_rs2_valid_c;
  logic               sh_we_c;

  chk_hits_t          hits_c;
  err_code_e          code_c;
  logic               pass_c;
  logic               order_bad_c;

  // The instruction word is carried for the ISA-level checker, not used here.
  logic               unused_insn;
  assign unused_insn = ^rvfi_insn;

  alion_shadow_rf #(.XLEN(XLEN)) u_shadow_rf (
    .clk        (clk),
    .rst_n      (rst_n),
    .ra_addr    (rvfi_rs1_addr),
    .rb_addr    (rvfi_rs2_addr),
    .ra_data_c  (sh_rs1_data_c),
    .rb_data_c  (sh_rs2_data_c),
    .ra_valid_c (sh_rs1_valid_c),
    .rb_valid_c (sh_rs2_valid_c),
    .we         (sh_we_c),
    .wr_addr    (rvfi_rd_addr),
    .wr_data    (rvfi_rd_wdata)
  );

`ifdef ALION_RVFI_ORDER_CHECK_EN
  logic [ORDER_W-1:0] prev_order_q, prev_order_d;

  // Track the order of the last passing retire (seeded by the first one).
  always_comb begin
    prev_order_d = prev_order_q;
    if (rvfi_valid && pass_c && ((state_q == WAIT_FIRST) || (state_q == RUN)))
      prev_order_d = rvfi_order;
  end

  // Previous-order register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_order_q <= '0;
    else        prev_order_q <= prev_order_d;
  end

  assign order_bad_c = (state_q == RUN) && (rvfi_order != (prev_order_q + ORDER_W'(1)));
`else
  assign order_bad_c = 1'b0;
`endif

  // Evaluate every per-retire check against the pre-write shadow state.
  always_comb begin
    hits_c             = '0;
    hits_c.x0_read     = ((rvfi_rs1_addr == '0) && (rvfi_rs1_rdata != '0)) ||
                         ((rvfi_rs2_addr == '0) && (rvfi_rs2_rdata != '0));
    hits_c.x0_write    = (rvfi_rd_addr == '0) && (rvfi_rd_wdata != '0);
    hits_c.rs_mismatch = ((rvfi_rs1_addr != '0) && sh_rs1_valid_c && (rvfi_rs1_rdata != sh_rs1_data_c)) ||
                         ((rvfi_rs2_addr != '0) && sh_rs2_valid_c && (rvfi_rs2_rdata != sh_rs2_data_c));
    hits_c.pc_discont  = (state_q == RUN) && !rvfi_intr && (rvfi_pc_rdata != prev_pc_q);
    hits_c.trap_write  = rvfi_trap && (rvfi_rd_addr != '0);
    hits_c.order       = order_bad_c;
    code_c             = first_err(hits_c);
    pass_c             = (code_c == NONE);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    err_order_d  = err_order_q;
    retire_cnt_d = retire_cnt_q;
    prev_pc_d    = prev_pc_q;
    sh_we_c      = 1'b0;
    case (state_q)
      WAIT_FIRST, RUN: begin
        if (rvfi_valid) begin
          if (!pass_c) begin
            state_d     = FAIL;
            err_d       = 1'b1;
            err_code_d  = code_c;
            err_order_d = rvfi_order;
          end else begin
            prev_pc_d = rvfi_pc_wdata;
            if (!rvfi_trap) begin
              sh_we_c = (rvfi_rd_addr != '0);
              if (retire_cnt_q != '1) retire_cnt_d = retire_cnt_q + CNT_W'(1);
            end
            state_d = rvfi_halt ? HALTED : RUN;
          end
        end
      end
      HALTED: begin
        if (rvfi_valid) begin
          state_d     = FAIL;
          err_d       = 1'b1;
          err_code_d  = RETIRE_AFTER_HALT;
          err_order_d = rvfi_order;
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_FIRST;
      err_q        <= 1'b0;
      err_code_q   <= NONE;
      err_order_q  <= '0;
      retire_cnt_q <= '0;
      prev_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      err_order_q  <= err_order_d;
      retire_cnt_q <= retire_cnt_d;
      prev_pc_q    <= prev_pc_d;
    end
  end

  assign err        = err_q;
  assign err_code   = err_code_q;
  assign err_order  = err_order_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_alion_rvfi_retire_checker.sv
// Self-checking bench for alion_rvfi_retire_checker: directed cases plus
// randomized retire streams compared against a behavioural model every cycle.
module tb_alion_rvfi_retire_checker;

  logic        clk;
  logic        rst_n;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic        rvfi_trap, rvfi_halt, rvfi_intr;
  logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
  logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
  logic [31:0] rvfi_pc_rdata, rvfi_pc_wdata;
  logic        err;
  logic [3:0]  err_code;
  logic [63:0] err_order;
  logic [31:0] retire_cnt;

  int total = 0;
  int bad   = 0;

  alion_rvfi_retire_checker #(.XLEN(32), .CNT_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rvfi_valid     (rvfi_valid),
    .rvfi_order     (rvfi_order),
    .rvfi_insn      (rvfi_insn),
    .rvfi_trap      (rvfi_trap),
    .rvfi_halt      (rvfi_halt),
    .rvfi_intr      (rvfi_intr),
    .rvfi_rs1_addr  (rvfi_rs1_addr),
    .rvfi_rs2_addr  (rvfi_rs2_addr),
    .rvfi_rs1_rdata (rvfi_rs1_rdata),
    .rvfi_rs2_rdata (rvfi_rs2_rdata),
    .rvfi_rd_addr   (rvfi_rd_addr),
    .rvfi_rd_wdata  (rvfi_rd_wdata),
    .rvfi_pc_rdata  (rvfi_pc_rdata),
    .rvfi_pc_wdata  (rvfi_pc_wdata),
    .err            (err),
    .err_code       (err_code),
    .err_order      (err_order),
    .retire_cnt     (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: phase of the stream, sticky error record, shadow regs.
  localparam int M_WAIT = 0, M_RUN = 1, M_HALT = 2, M_DEAD = 3;
  int          m_state;
  logic        m_err;
  logic [3:0]  m_code;
  logic [63:0] m_order;
  logic [31:0] m_cnt;
  logic [31:0] m_pc;
  logic [63:0] m_prev_ord;
  logic [31:0] m_sh [32];
  bit          m_sv [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_WAIT; m_err = 1'b0; m_code = 4'd0; m_order = 64'd0;
    m_cnt = 32'd0; m_pc = 32'd0; m_prev_ord = 64'd0;
    for (int i = 0; i < 32; i++) begin m_sv[i] = 1'b0; m_sh[i] = 32'd0; end
  endtask

  function automatic bit rs_bad(input logic [4:0] a, input logic [31:0] d);
    return (a != 5'd0) && m_sv[a] && (d != m_sh[a]);
  endfunction

  // Apply one clock edge's worth of the rules to the model.
  task automatic model_update();
    logic [3:0] code;
    if (!rst_n) begin model_reset(); return; end
    if (!rvfi_valid || m_state == M_DEAD) return;
    if (m_state == M_HALT) begin
      m_state = M_DEAD; m_err = 1'b1; m_code = 4'd7; m_order = rvfi_order;
      return;
    end
    // Collect failures from weakest to strongest so the lowest code survives.
    code = 4'd0;
`ifdef ALION_RVFI_ORDER_CHECK_EN
    if (m_state == M_RUN && rvfi_order != m_prev_ord + 64'd1) code = 4'd6;
`endif
    if (rvfi_trap && rvfi_rd_addr != 5'd0) code = 4'd5;
    if (m_state == M_RUN && !rvfi_intr && rvfi_pc_rdata != m_pc) code = 4'd4;
    if (rs_bad(rvfi_rs1_addr, rvfi_rs1_rdata) || rs_bad(rvfi_rs2_addr, rvfi_rs2_rdata)) code = 4'd3;
    if (rvfi_rd_addr == 5'd0 && rvfi_rd_wdata != 32'd0) code = 4'd2;
    if ((rvfi_rs1_addr == 5'd0 && rvfi_rs1_rdata != 32'd0) ||
        (rvfi_rs2_addr == 5'd0 && rvfi_rs2_rdata != 32'd0)) code = 4'd1;
    if (code != 4'd0) begin
      m_state = M_DEAD; m_err = 1'b1; m_code = code; m_order = rvfi_order;
      return;
    end
    m_pc = rvfi_pc_wdata;
    m_prev_ord = rvfi_order;
    if (!rvfi_trap) begin
      if (rvfi_rd_addr != 5'd0) begin
        m_sh[rvfi_rd_addr] = rvfi_rd_wdata;
        m_sv[rvfi_rd_addr] = 1'b1;
      end
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
    m_state = rvfi_halt ? M_HALT : M_RUN;
  endtask

  task automatic compare_all();
    chk("err", {63'd0, err}, {63'd0, m_err});
    chk("err_code", {60'd0, err_code}, {60'd0, m_code});
    chk("err_order", err_order, m_order);
    chk("retire_cnt", {32'd0, retire_cnt}, {32'd0, m_cnt});
  endtask

  // Inputs are set before the rising edge; outputs are checked on the falling edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    rvfi_valid = 1'b0; rvfi_order = 64'd0; rvfi_insn = 32'd0;
    rvfi_trap = 1'b0; rvfi_halt = 1'b0; rvfi_intr = 1'b0;
    rvfi_rs1_addr = 5'd0; rvfi_rs2_addr = 5'd0; rvfi_rd_addr = 5'd0;
    rvfi_rs1_rdata = 32'd0; rvfi_rs2_rdata = 32'd0; rvfi_rd_wdata = 32'd0;
    rvfi_pc_rdata = 32'd0; rvfi_pc_wdata = 32'd0;
  endtask

  // Drop reset between clock edges and expect outputs to clear immediately.
  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_code", {60'd0, err_code}, 64'd0);
    chk("rst_order", err_order, 64'd0);
    chk("rst_cnt", {32'd0, retire_cnt}, 64'd0);
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic ret(input logic [63:0] ord, input logic [31:0] pcr, input logic [31:0] pcw,
                     input logic [4:0] r1a, input logic [31:0] r1d,
                     input logic [4:0] rda, input logic [31:0] rdd,
                     input logic halt, input logic intr);
    idle_inputs();
    rvfi_valid = 1'b1; rvfi_order = ord; rvfi_pc_rdata = pcr; rvfi_pc_wdata = pcw;
    rvfi_rs1_addr = r1a; rvfi_rs1_rdata = r1d; rvfi_rs2_addr = r1a; rvfi_rs2_rdata = r1d;
    rvfi_rd_addr = rda; rvfi_rd_wdata = rdd; rvfi_halt = halt; rvfi_intr = intr;
    step();
    idle_inputs();
  endtask

  // Mostly-legal random retire derived from the model, with occasional faults.
  task automatic gen_retire();
    rvfi_valid = ($urandom_range(3) != 0);
    rvfi_insn  = $urandom();
    rvfi_order = (m_state == M_WAIT) ? {$urandom(), $urandom()} : m_prev_ord + 64'd1;
    if ($urandom_range(79) == 0) rvfi_order = rvfi_order + 64'd1;
    rvfi_intr = ($urandom_range(15) == 0);
    rvfi_pc_rdata = rvfi_intr ? ($urandom() & ~32'd3) : m_pc;
    if ($urandom_range(79) == 0) rvfi_pc_rdata = rvfi_pc_rdata + 32'd4;
    rvfi_pc_wdata = ($urandom_range(7) == 0) ? ($urandom() & ~32'd3) : rvfi_pc_rdata + 32'd4;
    rvfi_rs1_addr = 5'($urandom_range(31));
    rvfi_rs2_addr = 5'($urandom_range(31));
    rvfi_rs1_rdata = (rvfi_rs1_addr == 5'd0) ? 32'd0 : (m_sv[rvfi_rs1_addr] ? m_sh[rvfi_rs1_addr] : $urandom());
    rvfi_rs2_rdata = (rvfi_rs2_addr == 5'd0) ? 32'd0 : (m_sv[rvfi_rs2_addr] ? m_sh[rvfi_rs2_addr] : $urandom());
    if ($urandom_range(79) == 0) rvfi_rs1_rdata = rvfi_rs1_rdata ^ 32'd1;
    if ($urandom_range(79) == 0) rvfi_rs2_rdata = rvfi_rs2_rdata ^ 32'd2;
    rvfi_rd_addr  = 5'($urandom_range(31));
    rvfi_rd_wdata = (rvfi_rd_addr == 5'd0) ? 32'd0 : $urandom();
    if ($urandom_range(99) == 0) rvfi_rd_wdata = 32'd1;
    rvfi_trap = ($urandom_range(19) == 0);
    if (rvfi_trap && $urandom_range(3) != 0) begin rvfi_rd_addr = 5'd0; rvfi_rd_wdata = 32'd0; end
    rvfi_halt = (m_state == M_RUN) && ($urandom_range(49) == 0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();

    // 1: addi x1,x0,5 then add x2,x1,x1 with correct operands.
    async_reset();
    ret(64'd0, 32'h100, 32'h104, 5'd0, 32'd0, 5'd1, 32'd5, 1'b0, 1'b0);
    ret(64'd1, 32'h104, 32'h108, 5'd1, 32'd5, 5'd2, 32'd10, 1'b0, 1'b0);
    chk("t1_err", {63'd0, err}, 64'd0);
    chk("t1_cnt", {32'd0, retire_cnt}, 64'd2);

    // 2: stale source value on the second instruction.
    async_reset();
    ret(64'd10, 32'h100, 32'h104, 5'd0, 32'd0, 5'd1, 32'd5, 1'b0, 1'b0);
    ret(64'd11, 32'h104, 32'h108, 5'd1, 32'd6, 5'd2, 32'd10, 1'b0, 1'b0);
    chk("t2_err", {63'd0, err}, 64'd1);
    chk("t2_code", {60'd0, err_code}, 64'd3);
    chk("t2_order", err_order, 64'd11);
    chk("t2_cnt", {32'd0, retire_cnt}, 64'd1);

    // 3: PC jump without and with a trap-handler entry.
    async_reset();
    ret(64'd0, 32'h100, 32'h104, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0);
    ret(64'd1, 32'h108, 32'h10c, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("t3_code", {60'd0, err_code}, 64'd4);
    async_reset();
    ret(64'd0, 32'h100, 32'h104, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0);
    ret(64'd1, 32'h108, 32'h10c, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b1);
    chk("t3_intr_err", {63'd0, err}, 64'd0);

    // 4: x0 read beats PC discontinuity.
    async_reset();
    ret(64'd0, 32'h100, 32'h104, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0);
    ret(64'd1, 32'h200, 32'h204, 5'd0, 32'd1, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("t4_code", {60'd0, err_code}, 64'd1);

    // 5: retire after halt, then reset clears outputs and shadow validity.
    async_reset();
    ret(64'd0, 32'h100, 32'h104, 5'd0, 32'd0, 5'd1, 32'd5, 1'b0, 1'b0);
    ret(64'd1, 32'h104, 32'h108, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 1'b0);
    ret(64'd2, 32'h108, 32'h10c, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("t5_code", {60'd0, err_code}, 64'd7);
    chk("t5_order", err_order, 64'd2);
    async_reset();
    ret(64'd0, 32'h300, 32'h304, 5'd1, 32'd77, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("t5_shadow_cleared", {63'd0, err}, 64'd0);

    // 6: order gap.
    async_reset();
    ret(64'd0, 32'h100, 32'h104, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0);
    ret(64'd1, 32'h104, 32'h108, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0);
    ret(64'd3, 32'h108, 32'h10c, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0);
`ifdef ALION_RVFI_ORDER_CHECK_EN
    chk("t6_code", {60'd0, err_code}, 64'd6);
    chk("t6_order", err_order, 64'd3);
`else
    chk("t6_err", {63'd0, err}, 64'd0);
    chk("t6_cnt", {32'd0, retire_cnt}, 64'd3);
`endif

    // Randomized streams, some cut short by an asynchronous reset.
    for (int ep = 0; ep < 40; ep++) begin
      async_reset();
      for (int cyc = 0; cyc < 80; cyc++) begin
        if ((ep % 5 == 4) && cyc == 40) async_reset();
        gen_retire();
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
